// File: rtl/uart_rx_core_if.sv
// UART receiver link bundle: serial line, frame config, received-data outputs.
// master drives line/config and observes results; slave is the receiver core.
interface uart_rx_core_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [PRESC_W-1:0]    Prescale;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  Par_Err;
    logic                  Stp_Err;

    modport master (
        output RX_IN,
        output PAR_EN,
        output PAR_TYP,
        output Prescale,
        input  P_DATA,
        input  Data_Valid,
        input  Par_Err,
        input  Stp_Err
    );

    modport slave (
        input  RX_IN,
        input  PAR_EN,
        input  PAR_TYP,
        input  Prescale,
        output P_DATA,
        output Data_Valid,
        output Par_Err,
        output Stp_Err
    );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: oversampled, majority-voted deserialiser with parity/stop checks.
// Ports: CLK, RST (sync, active-high), rx (uart_rx_core_if.slave bundle).
module uart_rx_core #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic           CLK,
    input  logic           RST,
    uart_rx_core_if.slave  rx
);

    localparam int BCW = $clog2(DATA_WIDTH + 2) + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            sync_q, sync_d;
    logic [PRESC_W-1:0]    edge_cnt_q, edge_cnt_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [1:0]            samp_q, samp_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_bad_q, par_bad_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  dv_q, dv_d;
    logic                  pe_q, pe_d;
    logic                  se_q, se_d;

    logic                  rx_s;
    logic [PRESC_W-1:0]    half;
    logic                  at_lo;
    logic                  at_mid;
    logic                  at_vote;
    logic                  bit_end;
    logic                  vote;

    assign rx_s    = sync_q[1];
    assign half    = presc_q >> 1;
    assign at_lo   = (edge_cnt_q == half - PRESC_W'(1));
    assign at_mid  = (edge_cnt_q == half);
    assign at_vote = (edge_cnt_q == half + PRESC_W'(1));
    assign bit_end = (edge_cnt_q == presc_q - PRESC_W'(1));

    // The third sample is the live rx_s, so the voted bit is registered
    // and visible the cycle after edge_cnt = P/2+1.
    assign vote = (samp_q[1] & samp_q[0])
                | (samp_q[1] & rx_s)
                | (samp_q[0] & rx_s);

    always_comb begin
        state_d    = state_q;
        sync_d     = {sync_q[0], rx.RX_IN};
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        samp_d     = samp_q;
        data_d     = data_q;
        par_bad_d  = par_bad_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        presc_d    = presc_q;
        p_data_d   = p_data_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        se_d       = 1'b0;

        if (state_q != IDLE) begin
            if (bit_end) begin
                edge_cnt_d = '0;
                bit_cnt_d  = bit_cnt_q + BCW'(1);
            end else begin
                edge_cnt_d = edge_cnt_q + PRESC_W'(1);
            end
            if (at_lo || at_mid) begin
                samp_d = {samp_q[0], rx_s};
            end
        end

        unique case (state_q)
            IDLE: begin
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                // The cycle rx_s is first seen low counts as edge_cnt = 0.
                if (!rx_s) begin
                    state_d    = START;
                    edge_cnt_d = PRESC_W'(1);
                    par_en_d   = rx.PAR_EN;
                    par_typ_d  = rx.PAR_TYP;
                    presc_d    = rx.Prescale;
                    par_bad_d  = 1'b0;
                end
            end
            START: begin
                if (at_vote && vote) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (at_vote) begin
                    data_d = {vote, data_q[DATA_WIDTH-1:1]};
                end
                if (bit_end && bit_cnt_q == BCW'(DATA_WIDTH)) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (at_vote) begin
                    par_bad_d = vote != (^data_q ^ par_typ_q);
                end
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // Leave mid stop bit so a back-to-back start edge is caught.
                if (at_vote) begin
                    state_d = IDLE;
                    dv_d    = vote & ~par_bad_q;
                    pe_d    = par_bad_q;
                    se_d    = ~vote;
                    if (vote && !par_bad_q) begin
                        p_data_d = data_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            sync_q     <= 2'b11;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            samp_q     <= '0;
            data_q     <= '0;
            par_bad_q  <= 1'b0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            presc_q    <= '0;
            p_data_q   <= '0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            samp_q     <= samp_d;
            data_q     <= data_d;
            par_bad_q  <= par_bad_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            presc_q    <= presc_d;
            p_data_q   <= p_data_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
        end
    end

    assign rx.P_DATA     = p_data_q;
    assign rx.Data_Valid = dv_q;
    assign rx.Par_Err    = pe_q;
    assign rx.Stp_Err    = se_q;

endmodule
